// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-RAM port controller: default widths, op codes, FSM states.
// Range-clear support is selected by MEM_PORT_CTRL_RANGE_CLEAR_EN in the top module.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 20;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_SWEEP = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // The reserved encoding falls back to a plain load.
  function automatic logic [1:0] decode_op(input logic [1:0] op);
    logic [1:0] res;
    case (op)
      OP_STORE: res = OP_STORE;
      OP_CLEAR: res = OP_CLEAR;
      default:  res = OP_LOAD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Request/response channel between the pipeline memory stage (master) and the
// data-RAM port controller (slave).
interface mem_port_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              Req_Valid;
  logic              Req_Ready;
  logic [1:0]        Req_Op;
  logic [ADDR_W-1:0] Req_Addr;
  logic [DATA_W-1:0] Req_Data;
  logic [ADDR_W-1:0] Req_Len;
  logic              Rsp_Valid;
  logic              Rsp_Ready;
  logic [DATA_W-1:0] Rsp_Data;

  modport master (
    output Req_Valid, Req_Op, Req_Addr, Req_Data, Req_Len, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Data
  );

  modport slave (
    input  Req_Valid, Req_Op, Req_Addr, Req_Data, Req_Len, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Data
  );

endinterface

// File: rtl/mem_port_ctrl_sweep_cnt.sv
// Loadable wrapping address counter plus remaining-word down-counter for range clears.
// Only instantiated when MEM_PORT_CTRL_RANGE_CLEAR_EN is defined.
module mem_sweep_cnt #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_next,
  output logic              done
);

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] rem_r;

  // Address wraps naturally at 2^ADDR_W; remaining count steps down alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
      rem_r  <= {ADDR_W{1'b0}};
    end else if (load) begin
      addr_r <= load_addr;
      rem_r  <= load_len;
    end else if (en) begin
      addr_r <= addr_r + ADDR_W'(1);
      rem_r  <= rem_r - ADDR_W'(1);
    end
  end

  assign addr      = addr_r;
  assign addr_next = addr_r + ADDR_W'(1);
  assign done      = (rem_r == {ADDR_W{1'b0}});

endmodule

// File: rtl/mem_port_ctrl.sv
// Initiator side of the data RAM: sequences load/store/clear requests onto the RAM pins.
// MEM_PORT_CTRL_RANGE_CLEAR_EN enables multi-word CLEAR sweeps; otherwise CLEAR zeros one word.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  mem_port_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_Load,
  output logic              Mem_Clear,
  output logic [DATA_W-1:0] Mem_DataIn,
  input  logic [DATA_W-1:0] Mem_DataOut
);

  state_t            state_r, state_n;
  logic              req_ready_r, req_ready_n;
  logic              rsp_valid_r, rsp_valid_n;
  logic [DATA_W-1:0] rsp_data_r, rsp_data_n;
  logic [ADDR_W-1:0] mem_address_r, mem_address_n;
  logic              mem_load_r, mem_load_n;
  logic              mem_clear_r, mem_clear_n;
  logic [DATA_W-1:0] mem_data_in_r, mem_data_in_n;

  logic              sweep_load_s;
  logic              sweep_en_s;
  logic              sweep_done_s;
  logic [ADDR_W-1:0] sweep_next_s;

`ifdef MEM_PORT_CTRL_RANGE_CLEAR_EN
  logic [ADDR_W-1:0] sweep_addr_s;
  logic              unused_sweep_s;

  mem_sweep_cnt #(.ADDR_W(ADDR_W)) u_sweep (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .load      (sweep_load_s),
    .load_addr (bus.Req_Addr),
    .load_len  (bus.Req_Len),
    .en        (sweep_en_s),
    .addr      (sweep_addr_s),
    .addr_next (sweep_next_s),
    .done      (sweep_done_s)
  );

  assign unused_sweep_s = ^sweep_addr_s;
`else
  logic unused_sweep_s;

  // Single-word clear: the sweep ends after its first cycle.
  assign sweep_done_s   = 1'b1;
  assign sweep_next_s   = mem_address_r;
  assign unused_sweep_s = ^{sweep_load_s, sweep_en_s, bus.Req_Len};
`endif

  // RAM pins are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_n       = state_r;
    req_ready_n   = req_ready_r;
    rsp_valid_n   = rsp_valid_r;
    rsp_data_n    = rsp_data_r;
    mem_address_n = mem_address_r;
    mem_load_n    = 1'b1;
    mem_clear_n   = 1'b0;
    mem_data_in_n = {DATA_W{1'b0}};
    sweep_load_s  = 1'b0;
    sweep_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_n = 1'b1;
        if (bus.Req_Valid && req_ready_r) begin
          req_ready_n   = 1'b0;
          mem_address_n = bus.Req_Addr;
          case (decode_op(bus.Req_Op))
            OP_STORE: begin
              state_n       = ST_WRITE;
              mem_load_n    = 1'b0;
              mem_data_in_n = bus.Req_Data;
            end
            OP_CLEAR: begin
              state_n      = ST_SWEEP;
              mem_clear_n  = 1'b1;
              sweep_load_s = 1'b1;
            end
            default: begin
              state_n = ST_READ;
            end
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_READ: begin
        state_n     = ST_RESP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = Mem_DataOut;
      end
      ST_WRITE: begin
        state_n     = ST_RESP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = {DATA_W{1'b0}};
      end
      ST_SWEEP: begin
        if (sweep_done_s) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_data_n  = {DATA_W{1'b0}};
        end else begin
          sweep_en_s    = 1'b1;
          mem_clear_n   = 1'b1;
          mem_address_n = sweep_next_s;
        end
      end
      ST_RESP: begin
        if (bus.Rsp_Ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
        end else begin
          state_n = ST_RESP;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        req_ready_n = 1'b1;
        rsp_valid_n = 1'b0;
      end
    endcase
  end

  // Reset forces Mem_Load high and Mem_Clear low immediately so no stray write/clear lands.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= {DATA_W{1'b0}};
      mem_address_r <= {ADDR_W{1'b0}};
      mem_load_r    <= 1'b1;
      mem_clear_r   <= 1'b0;
      mem_data_in_r <= {DATA_W{1'b0}};
    end else begin
      state_r       <= state_n;
      req_ready_r   <= req_ready_n;
      rsp_valid_r   <= rsp_valid_n;
      rsp_data_r    <= rsp_data_n;
      mem_address_r <= mem_address_n;
      mem_load_r    <= mem_load_n;
      mem_clear_r   <= mem_clear_n;
      mem_data_in_r <= mem_data_in_n;
    end
  end

  assign bus.Req_Ready = req_ready_r;
  assign bus.Rsp_Valid = rsp_valid_r;
  assign bus.Rsp_Data  = rsp_data_r;
  assign Mem_Address   = mem_address_r;
  assign Mem_Load      = mem_load_r;
  assign Mem_Clear     = mem_clear_r;
  assign Mem_DataIn    = mem_data_in_r;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: behavioural RAM plus an array reference model.
// Honours MEM_PORT_CTRL_RANGE_CLEAR_EN for the expected CLEAR extent.
module tb_mem_port_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 20;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] mem_address;
  logic          mem_load;
  logic          mem_clear;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock       (clk),
    .Reset_n     (rst_n),
    .bus         (bus.slave),
    .Mem_Address (mem_address),
    .Mem_Load    (mem_load),
    .Mem_Clear   (mem_clear),
    .Mem_DataIn  (mem_data_in),
    .Mem_DataOut (mem_data_out)
  );

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ram_init = 1'b0;
  logic [31:0]   seed;
  int            vectors = 0;
  int            errs    = 0;

  function automatic logic [DW-1:0] init_pat(input int i, input logic [31:0] s);
    logic [31:0] v;
    v = (i * 32'h9E37_79B9) ^ s;
    return v[DW-1:0];
  endfunction

  // RAM: writes on every edge with load low, clears the addressed word when asked.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_pat(i, seed);
    end else if (!mem_load) begin
      ram[mem_address] <= mem_data_in;
    end else if (mem_clear) begin
      ram[mem_address] <= '0;
    end
  end
  assign mem_data_out = ram[mem_address];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what a request should do to memory, and what it should look like on the pins.
  task automatic model(input logic [1:0] op, input int addr, input logic [DW-1:0] data,
                       input int len, output logic [DW-1:0] rsp, output int lat,
                       output int low, output int clr);
    int n;
    rsp = '0; lat = 2; low = 0; clr = 0;
    if (op == OP_STORE) begin
      ref_mem[addr] = data;
      low = 1;
    end else if (op == OP_CLEAR) begin
`ifdef MEM_PORT_CTRL_RANGE_CLEAR_EN
      n = len + 1;
`else
      n = 1;
`endif
      for (int k = 0; k < n; k++) ref_mem[(addr + k) % DEPTH] = '0;
      lat = n + 1;
      clr = n;
    end else begin
      rsp = ref_mem[addr];
    end
  endtask

  task automatic do_op(input logic [1:0] op, input int addr, input logic [DW-1:0] data,
                       input int len, input int stall);
    logic [DW-1:0] exp_rsp, held;
    int lat, exp_low, exp_clr, w, cyc, lowc, clrc;
    model(op, addr, data, len, exp_rsp, lat, exp_low, exp_clr);
    w = 0;
    while (bus.Req_Ready !== 1'b1 && w < 50) begin tick(); w++; end
    chk("req_ready_idle", 32'(bus.Req_Ready), 32'd1);
    bus.Req_Op = op; bus.Req_Addr = AW'(addr); bus.Req_Data = data; bus.Req_Len = AW'(len);
    bus.Req_Valid = 1'b1;
    tick();
    bus.Req_Valid = 1'b0;
    bus.Req_Data  = DW'($urandom);
    cyc = 1; lowc = 0; clrc = 0;
    chk("req_ready_busy", 32'(bus.Req_Ready), 32'd0);
    while (bus.Rsp_Valid !== 1'b1 && cyc < 3000) begin
      if (mem_load !== 1'b1) lowc++;
      if (mem_clear === 1'b1) begin
        chk("sweep_addr", 32'(mem_address), 32'((addr + clrc) % DEPTH));
        clrc++;
      end
      if (cyc == 1 && op != OP_CLEAR) chk("mem_addr", 32'(mem_address), 32'(addr));
      if (cyc == 1 && op == OP_STORE) chk("mem_din", 32'(mem_data_in), 32'(data));
      else chk("din_zero", 32'(mem_data_in), 32'd0);
      tick();
      cyc++;
    end
    chk("rsp_latency", 32'(cyc), 32'(lat));
    chk("load_low_cycles", 32'(lowc), 32'(exp_low));
    chk("clear_cycles", 32'(clrc), 32'(exp_clr));
    held = bus.Rsp_Data;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 32'(bus.Rsp_Valid), 32'd1);
      chk("stall_data", 32'(bus.Rsp_Data), 32'(held));
      chk("stall_ready", 32'(bus.Req_Ready), 32'd0);
      chk("stall_pins", {29'd0, mem_load, mem_clear, |mem_data_in}, {29'd0, 1'b1, 1'b0, 1'b0});
      tick();
    end
    chk("rsp_data", 32'(bus.Rsp_Data), 32'(exp_rsp));
    bus.Rsp_Ready = 1'b1;
    tick();
    bus.Rsp_Ready = 1'b0;
    chk("rsp_drop", 32'(bus.Rsp_Valid), 32'd0);
    chk("ready_after_rsp", 32'(bus.Req_Ready), 32'd1);
  endtask

  task automatic check_image(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk(tag, 32'(mism), 32'd0);
  endtask

  initial begin
    int lowc, dinc, ncl, a;
    int win[5];
    bus.Req_Valid = 1'b0; bus.Req_Op = 2'd0; bus.Req_Addr = '0;
    bus.Req_Data = '0; bus.Req_Len = '0; bus.Rsp_Ready = 1'b0;
    seed = $urandom;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_pat(i, seed);
    ram_init = 1'b1;
    tick();
    ram_init = 1'b0;

    // Reset values.
    chk("rst_req_ready", 32'(bus.Req_Ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.Rsp_Data), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_mem_load", 32'(mem_load), 32'd1);
    chk("rst_mem_clear", 32'(mem_clear), 32'd0);
    chk("rst_mem_din", 32'(mem_data_in), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Store then load back.
    do_op(OP_STORE, 32'h005, 20'h12345, 0, 0);
    do_op(OP_LOAD, 32'h005, 20'h0, 0, 0);
    chk("load_new_data", 32'(bus.Rsp_Data), 32'h12345);

    // Wrapping range clear.
    win = '{32'h3FD, 32'h3FE, 32'h3FF, 32'h000, 32'h001};
    foreach (win[i]) do_op(OP_STORE, win[i], 20'hFFFFF, 0, 0);
    do_op(OP_CLEAR, 32'h3FE, 20'h0, 2, 0);
    foreach (win[i]) do_op(OP_LOAD, win[i], 20'h0, 0, 0);

    // Response back-pressure, then an immediate follow-on request.
    do_op(OP_LOAD, 32'h123, 20'h0, 0, 5);
    do_op(OP_STORE, 32'h124, 20'hABCDE, 0, 0);

    // Reset in the middle of a 16-word clear.
    bus.Req_Op = OP_CLEAR; bus.Req_Addr = 10'h200; bus.Req_Len = 10'd15;
    bus.Req_Valid = 1'b1;
    tick();
    bus.Req_Valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clear", 32'(mem_clear), 32'd0);
    chk("mid_rst_load", 32'(mem_load), 32'd1);
    chk("mid_rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
`ifdef MEM_PORT_CTRL_RANGE_CLEAR_EN
    ncl = 4;
`else
    ncl = 1;
`endif
    for (int k = 0; k < ncl; k++) ref_mem[32'h200 + k] = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.Req_Ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
    for (int k = 0; k < 16; k++) do_op(OP_LOAD, 32'h200 + k, 20'h0, 0, 0);

    // Idle with noise on the request fields.
    lowc = 0; dinc = 0;
    for (int c = 0; c < 100; c++) begin
      bus.Req_Data = DW'($urandom);
      bus.Req_Addr = AW'($urandom);
      if (mem_load !== 1'b1) lowc++;
      if (mem_data_in !== '0) dinc++;
      tick();
    end
    chk("idle_load_low", 32'(lowc), 32'd0);
    chk("idle_din", 32'(dinc), 32'd0);
    check_image("idle_image");

    // Reserved opcode reads like a load.
    do_op(2'd3, 32'h010, 20'h0, 0, 0);
    chk("op3_data", 32'(bus.Rsp_Data), 32'(ref_mem[32'h010]));

    // Random traffic around the wrap point.
    for (int t = 0; t < 40; t++) begin
      a = (32'h3F8 + $urandom_range(0, 15)) % DEPTH;
      do_op(2'($urandom_range(0, 3)), a, DW'($urandom), $urandom_range(0, 5),
            $urandom_range(0, 3));
    end
    check_image("final_image");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
